// File: rtl/b_bus_pkg.sv
// b_bus_pkg: shared types, source map and index helper for the B-bus selector.
package b_bus_pkg;
  localparam int BBUS_DATA_W  = 32;
  localparam int BBUS_NUM_SRC = 17;
  typedef enum logic {MODE_SINGLE, MODE_BURST} bbus_mode_e;
  typedef enum logic {IDLE, STREAM} bbus_state_e;
  localparam int SRC_MDR  = 0;
  localparam int SRC_K0   = 1;
  localparam int SRC_K1   = 2;
  localparam int SRC_K2   = 3;
  localparam int SRC_K3   = 4;
  localparam int SRC_K4   = 5;
  localparam int SRC_K5   = 6;
  localparam int SRC_K6   = 7;
  localparam int SRC_K7   = 8;
  localparam int SRC_K8   = 9;
  localparam int SRC_P1   = 10;
  localparam int SRC_P2   = 11;
  localparam int SRC_P3   = 12;
  localparam int SRC_DP   = 13;
  localparam int SRC_CV   = 14;
  localparam int SRC_I    = 15;
  localparam int SRC_MBRU = 16;
  // Out-of-range indices fall back to 0, as does the last valid source.
  function automatic int unsigned next_idx(input int unsigned cur, input int unsigned num_src);
    return (cur >= num_src - 1) ? 0 : cur + 1;
  endfunction
endpackage

// File: rtl/b_bus_out_stage.sv
// b_bus_out_stage: one-deep valid/ready output register for the B-bus beat.
module b_bus_out_stage #(
  parameter int DATA_W = 32,
  parameter int SEL_W  = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [DATA_W-1:0] in_data,
  input  logic [SEL_W-1:0]  in_sel,
  input  logic              in_last,
  input  logic              in_err,
  input  logic              out_ready,
  output logic              slot_free,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic [SEL_W-1:0]  out_sel,
  output logic              out_last,
  output logic              out_err
);
  logic              valid_q, valid_d, last_q, last_d, err_q, err_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [SEL_W-1:0]  sel_q, sel_d;
  always_comb begin
    valid_d = load | (valid_q & ~out_ready);
    data_d  = load ? in_data : data_q;
    sel_d   = load ? in_sel : sel_q;
    last_d  = load ? in_last : last_q;
    err_d   = load ? in_err : err_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      sel_q   <= '0;
      last_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      sel_q   <= sel_d;
      last_q  <= last_d;
      err_q   <= err_d;
    end
  end
  assign slot_free = ~valid_q | out_ready;
  assign out_valid = valid_q;
  assign out_data  = data_q;
  assign out_sel   = sel_q;
  assign out_last  = last_q;
  assign out_err   = err_q;
endmodule

// File: rtl/b_bus_seq_mux.sv
// b_bus_seq_mux: registered B-bus source selector with single-beat and burst walk modes.
module b_bus_seq_mux
  import b_bus_pkg::*;
#(
  parameter int DATA_W  = BBUS_DATA_W,
  parameter int NUM_SRC = BBUS_NUM_SRC,
  parameter int SEL_W   = $clog2(NUM_SRC)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_SRC*DATA_W-1:0] src_data,
  input  logic                      cmd_valid,
  output logic                      cmd_ready,
  input  logic                      cmd_mode,
  input  logic [SEL_W-1:0]          cmd_sel,
  input  logic [SEL_W-1:0]          cmd_len,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [DATA_W-1:0]         out_data,
  output logic [SEL_W-1:0]          out_sel,
  output logic                      out_last,
  output logic                      out_err,
  output logic                      busy
);
  bbus_state_e       state_q, state_d;
  logic [SEL_W-1:0]  cur_q, cur_d, rem_q, rem_d, idx;
  logic              rdy_q, rdy_d, load, last, err, slot_free;
  logic [DATA_W-1:0] mux_data;
  always_comb begin
    state_d   = state_q;
    cur_d     = cur_q;
    rem_d     = rem_q;
    rdy_d     = 1'b1;
    load      = 1'b0;
    idx       = cmd_sel;
    last      = 1'b1;
    cmd_ready = 1'b0;
    if (state_q == IDLE) begin
      cmd_ready = rdy_q & slot_free;
      if (cmd_valid && cmd_ready) begin
        load = 1'b1;
        if (bbus_mode_e'(cmd_mode) == MODE_BURST && cmd_len != '0) begin
          last    = 1'b0;
          cur_d   = SEL_W'(next_idx(32'(cmd_sel), NUM_SRC));
          rem_d   = cmd_len - SEL_W'(1);
          state_d = STREAM;
        end
      end
    end else if (slot_free) begin
      load = 1'b1;
      idx  = cur_q;
      last = rem_q == '0;
      if (rem_q == '0) state_d = IDLE;
      else begin
        cur_d = SEL_W'(next_idx(32'(cur_q), NUM_SRC));
        rem_d = rem_q - SEL_W'(1);
      end
    end
  end
  // Source is sampled only on the load edge; out-of-range indices read as zero.
  always_comb begin
    mux_data = '0;
    for (int i = 0; i < NUM_SRC; i++)
      if (32'(idx) == i) mux_data = src_data[i*DATA_W +: DATA_W];
    err = 32'(idx) >= NUM_SRC;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cur_q   <= '0;
      rem_q   <= '0;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      rem_q   <= rem_d;
      rdy_q   <= rdy_d;
    end
  end
  b_bus_out_stage #(.DATA_W(DATA_W), .SEL_W(SEL_W)) u_out (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (load),
    .in_data   (mux_data),
    .in_sel    (idx),
    .in_last   (last),
    .in_err    (err),
    .out_ready (out_ready),
    .slot_free (slot_free),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_sel   (out_sel),
    .out_last  (out_last),
    .out_err   (out_err)
  );
  assign busy = (state_q == STREAM) | out_valid;
endmodule

// File: tb/tb_b_bus_seq_mux.sv
// tb_b_bus_seq_mux: directed self-checking bench for the B-bus sequential selector.
module tb_b_bus_seq_mux;
  localparam int DW = 32;
  localparam int NS = 17;
  localparam int SW = 5;
  logic              clk, rst_n, cmd_valid, cmd_ready, cmd_mode, out_valid, out_ready;
  logic              out_last, out_err, busy;
  logic [NS*DW-1:0]  src_data;
  logic [SW-1:0]     cmd_sel, cmd_len, out_sel;
  logic [DW-1:0]     out_data;
  int                n_chk = 0;
  int                n_fail = 0;

  b_bus_seq_mux dut (
    .clk(clk), .rst_n(rst_n), .src_data(src_data),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_mode(cmd_mode),
    .cmd_sel(cmd_sel), .cmd_len(cmd_len),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_sel(out_sel), .out_last(out_last), .out_err(out_err), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] exp_data(input int idx);
    return (idx >= NS) ? '0 : 32'hA000_0000 + idx;
  endfunction

  task automatic beat(input string tag, input int idx, input bit last);
    chk({tag, ".valid"}, 64'(out_valid), 64'd1);
    chk({tag, ".sel"},   64'(out_sel),   64'(idx));
    chk({tag, ".data"},  64'(out_data),  64'(exp_data(idx)));
    chk({tag, ".last"},  64'(out_last),  64'(last));
    chk({tag, ".err"},   64'(out_err),   64'(idx >= NS));
  endtask

  task automatic cmd(input bit mode, input int sel, input int len);
    cmd_valid = 1'b1;
    cmd_mode  = mode;
    cmd_sel   = SW'(sel);
    cmd_len   = SW'(len);
  endtask

  initial begin
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_mode = 1'b0; cmd_sel = '0; cmd_len = '0; out_ready = 1'b1;
    for (int i = 0; i < NS; i++) src_data[i*DW +: DW] = 32'hA000_0000 + i;
    @(negedge clk);
    chk("rst.cmd_ready", 64'(cmd_ready), 64'd0);
    chk("rst.out_valid", 64'(out_valid), 64'd0);
    chk("rst.out_data",  64'(out_data),  64'd0);
    chk("rst.busy",      64'(busy),      64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst.cmd_ready", 64'(cmd_ready), 64'd1);

    cmd(0, 14, 0);
    @(negedge clk); cmd_valid = 1'b0;
    beat("single14", 14, 1);
    @(negedge clk);
    chk("single14.drain", 64'(out_valid), 64'd0);

    cmd(1, 1, 8);
    @(negedge clk); cmd_valid = 1'b0;
    for (int k = 0; k < 9; k++) begin
      beat($sformatf("kburst%0d", k + 1), 1 + k, k == 8);
      if (k < 8) chk("kburst.cmd_ready", 64'(cmd_ready), 64'd0);
      if (k < 8) chk("kburst.busy", 64'(busy), 64'd1);
      @(negedge clk);
    end
    chk("kburst.drain", 64'(out_valid), 64'd0);

    cmd(1, 1, 8);
    @(negedge clk); cmd_valid = 1'b0;
    for (int k = 0; k < 9; k++) begin
      beat($sformatf("bp%0d", k + 1), 1 + k, k == 8);
      if (k == 2) begin
        out_ready = 1'b0;
        src_data[3*DW +: DW] = 32'hDEAD_BEEF;
        for (int s = 0; s < 3; s++) begin
          @(negedge clk);
          beat($sformatf("bp_stall%0d", s), 3, 0);
        end
        src_data[3*DW +: DW] = 32'hA000_0003;
        out_ready = 1'b1;
      end
      @(negedge clk);
    end
    chk("bp.drain", 64'(out_valid), 64'd0);

    cmd(1, 15, 3);
    @(negedge clk); cmd_valid = 1'b0;
    beat("wrap0", 15, 0); @(negedge clk);
    beat("wrap1", 16, 0); @(negedge clk);
    beat("wrap2", 0, 0);  @(negedge clk);
    beat("wrap3", 1, 1);
    cmd(0, 0, 0);
    #1 chk("b2b.cmd_ready", 64'(cmd_ready), 64'd1);
    @(negedge clk); cmd_valid = 1'b0;
    beat("b2b", 0, 1);
    @(negedge clk);
    chk("b2b.drain", 64'(out_valid), 64'd0);

    cmd(0, 20, 0);
    @(negedge clk); cmd_valid = 1'b0;
    beat("inv20", 20, 1);
    @(negedge clk);
    cmd(1, 31, 1);
    @(negedge clk); cmd_valid = 1'b0;
    beat("inv31", 31, 0); @(negedge clk);
    beat("inv31_next", 0, 1); @(negedge clk);
    chk("inv.drain", 64'(out_valid), 64'd0);

    cmd(1, 1, 8);
    @(negedge clk); cmd_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      beat($sformatf("rb%0d", k + 1), 1 + k, 0);
      @(negedge clk);
    end
    beat("rb4", 4, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("arst.out_valid", 64'(out_valid), 64'd0);
    chk("arst.out_data",  64'(out_data),  64'd0);
    chk("arst.out_sel",   64'(out_sel),   64'd0);
    chk("arst.out_last",  64'(out_last),  64'd0);
    chk("arst.busy",      64'(busy),      64'd0);
    chk("arst.cmd_ready", 64'(cmd_ready), 64'd0);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    chk("arst.post_ready", 64'(cmd_ready), 64'd1);
    chk("arst.post_busy",  64'(busy),      64'd0);
    cmd(0, 16, 0);
    @(negedge clk); cmd_valid = 1'b0;
    beat("arst.mbru", 16, 1);
    @(negedge clk);
    chk("arst.drain", 64'(out_valid), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
